// File: rtl/opb_gbe_link_monitor_if.sv
// OPB slave-side bus bundle for the gbe link monitor: master request signals
// and slave response signals, with master/slave views.
interface opb_gbe_link_monitor_if;
   logic [0:31] OPB_ABus;
   logic [0:3]  OPB_BE;
   logic [0:31] OPB_DBus;
   logic        OPB_RNW;
   logic        OPB_select;
   logic        OPB_seqAddr;
   logic [0:31] Sl_DBus;
   logic        Sl_xferAck;
   logic        Sl_errAck;
   logic        Sl_retry;
   logic        Sl_toutSup;

   modport master (
      output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );

   modport slave (
      input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );
endinterface

// File: rtl/opb_gbe_link_monitor.sv
// OPB slave that debounces the gbe link-up flag and counts stable up/down transitions.
// Optional uptime counter at word 4 is enabled by defining GBE_LINK_UPTIME_EN.
module opb_gbe_link_monitor #(
   parameter logic [31:0] C_BASEADDR      = 32'h01080300,
   parameter logic [31:0] C_HIGHADDR      = 32'h010803FF,
   parameter int          DEBOUNCE_CYCLES = 1024,
   parameter int          CNT_WIDTH       = 32
) (
   input  logic                         OPB_Clk,
   input  logic                         OPB_Rst_n,
   opb_gbe_link_monitor_if.slave        opb,
   input  logic                         link_raw,
   output logic                         link_stable
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [31:0]           w_addr;
   logic [31:0]           w_word;
   logic                  w_hit;
   logic [31:0]           r_word;
   logic                  r_rnw;
   logic                  r_be3;
   logic                  r_wclr;
   logic                  r_wfrz;
   logic                  r_raw_q;
   logic                  r_stable;
   logic [DW-1:0]         r_dcnt;
   logic                  r_freeze;
   logic [CNT_WIDTH-1:0]  r_up_cnt;
   logic [CNT_WIDTH-1:0]  r_dn_cnt;
   logic                  w_flip;
   logic                  w_rise;
   logic                  w_fall;
   logic                  w_wr_ctrl;
   logic                  w_clear;
   logic [31:0]           w_rdata;
`ifdef GBE_LINK_UPTIME_EN
   logic [31:0]           r_uptime;
`endif

   assign w_addr = opb.OPB_ABus;
   assign w_hit  = opb.OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
   assign w_word = (w_addr - C_BASEADDR) >> 2;

   assign opb.Sl_errAck  = 1'b0;
   assign opb.Sl_retry   = 1'b0;
   assign opb.Sl_toutSup = 1'b0;
   assign link_stable    = r_stable;

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_hit) w_next = S_ACK;
         S_ACK:   w_next = S_HOLD;
         S_HOLD:  if (!opb.OPB_select) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      opb.Sl_xferAck = 1'b0;
      opb.Sl_DBus    = '0;
      if (r_state == S_ACK) begin
         opb.Sl_xferAck = 1'b1;
         opb.Sl_DBus    = w_rdata;
      end
   end

   // Capture the access at the hit so the ACK cycle works on a stable copy;
   // only the two control bits of the LSB byte matter for writes.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         r_word <= '0;
         r_rnw  <= 1'b1;
         r_be3  <= 1'b0;
         r_wclr <= 1'b0;
         r_wfrz <= 1'b0;
      end else if (r_state == S_IDLE && w_hit) begin
         r_word <= w_word;
         r_rnw  <= opb.OPB_RNW;
         r_be3  <= opb.OPB_BE[3];
         r_wclr <= opb.OPB_DBus[31];
         r_wfrz <= opb.OPB_DBus[30];
      end
   end

   assign w_flip    = (r_raw_q != r_stable) && (r_dcnt == DW'(DEBOUNCE_CYCLES - 1));
   assign w_rise    = w_flip && !r_stable;
   assign w_fall    = w_flip && r_stable;
   assign w_wr_ctrl = (r_state == S_ACK) && !r_rnw && (r_word == 32'd3) && r_be3;
   assign w_clear   = w_wr_ctrl && r_wclr;

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         r_raw_q  <= 1'b0;
         r_stable <= 1'b0;
         r_dcnt   <= '0;
      end else begin
         r_raw_q <= link_raw;
         if (r_raw_q == r_stable) begin
            r_dcnt <= '0;
         end else if (w_flip) begin
            r_stable <= ~r_stable;
            r_dcnt   <= '0;
         end else begin
            r_dcnt <= r_dcnt + DW'(1);
         end
      end
   end

   // Clear beats a coincident edge, and still works while frozen.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         r_freeze <= 1'b0;
         r_up_cnt <= '0;
         r_dn_cnt <= '0;
      end else begin
         if (w_wr_ctrl) r_freeze <= r_wfrz;
         if (w_clear) begin
            r_up_cnt <= '0;
            r_dn_cnt <= '0;
         end else if (!r_freeze) begin
            if (w_rise && !(&r_up_cnt)) r_up_cnt <= r_up_cnt + CNT_WIDTH'(1);
            if (w_fall && !(&r_dn_cnt)) r_dn_cnt <= r_dn_cnt + CNT_WIDTH'(1);
         end
      end
   end

`ifdef GBE_LINK_UPTIME_EN
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n)                                r_uptime <= '0;
      else if (w_fall || w_clear)                    r_uptime <= '0;
      else if (r_stable && !r_freeze && !(&r_uptime)) r_uptime <= r_uptime + 32'd1;
   end
`endif

   always_comb begin
      w_rdata = '0;
      case (r_word)
         32'd0:   w_rdata = {29'd0, r_freeze, r_raw_q, r_stable};
         32'd1:   w_rdata = 32'(r_up_cnt);
         32'd2:   w_rdata = 32'(r_dn_cnt);
         32'd3:   w_rdata = {30'd0, r_freeze, 1'b0};
`ifdef GBE_LINK_UPTIME_EN
         32'd4:   w_rdata = r_uptime;
`endif
         default: w_rdata = '0;
      endcase
   end

endmodule
